// File: rtl/sa_host_driver.sv
// Host-side job driver for the 4x4 systolic array: loads memories, starts, drains results.
// Optional ap_done watchdog enabled by defining SA_DRV_TIMEOUT_EN.
module sa_host_driver #(
  parameter int ROWS        = 4,
  parameter int COL_DEPTH   = 256,
  parameter int RES_PER_I   = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_start,
  input  logic [2:0]  job_ninstr,
  input  logic [8:0]  job_ncols,
  output logic        busy,
  output logic        err,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        sa_rst,
  output logic [2:0]  addrI,
  output logic [3:0]  dataI,
  output logic        enI,
  output logic [9:0]  addrA,
  output logic [15:0] dataA,
  output logic        enA,
  output logic [9:0]  addrB,
  output logic [15:0] dataB,
  output logic        enB,
  output logic        ap_start,
  input  logic        ap_done,
  output logic [6:0]  addrO,
  input  logic [31:0] dataO
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_SRST  = 4'd1;
  localparam logic [3:0] S_LDI   = 4'd2;
  localparam logic [3:0] S_LDA   = 4'd3;
  localparam logic [3:0] S_LDB   = 4'd4;
  localparam logic [3:0] S_TERM  = 4'd5;
  localparam logic [3:0] S_START = 4'd6;
  localparam logic [3:0] S_WAIT  = 4'd7;
  localparam logic [3:0] S_RDA   = 4'd8;
  localparam logic [3:0] S_RDD   = 4'd9;
  localparam logic [3:0] S_RDO   = 4'd10;

  logic [3:0]  state_q, state_d;
  logic [2:0]  ninstr_q, ninstr_d;
  logic [8:0]  ncols_q, ncols_d;
  logic [9:0]  idx_q, idx_d;
  logic [6:0]  raddr_q, raddr_d;
  logic [31:0] odata_q, odata_d;
  logic        err_q, err_d;
`ifdef SA_DRV_TIMEOUT_EN
  logic [31:0] wcnt_q, wcnt_d;
`else
  localparam int tmo_unused = TIMEOUT_CYC;
`endif

  logic        run;
  logic        xfer;
  logic        in_end;
  logic        op_end;
  logic        res_last;
  logic [10:0] op_last;
  logic [6:0]  res_end;
  logic [31:0] op_row;
  logic [31:0] op_col;
  logic [9:0]  op_addr;
  logic        bad_word;

  // reset gates every output so an abort takes effect in the same cycle
  assign run      = !rst;
  assign in_ready = run & ((state_q == S_LDI) |
                           (state_q == S_LDA) |
                           (state_q == S_LDB));
  assign xfer     = in_valid & in_ready;
  assign in_end   = idx_q == ({7'd0, ninstr_q} - 10'd1);
  assign op_last  = 11'(32'(ncols_q) * 32'(ROWS) - 32'd1);
  assign op_end   = {1'b0, idx_q} == op_last;
  assign res_end  = 7'(32'(ninstr_q) * 32'(RES_PER_I) - 32'd1);
  assign res_last = raddr_q == res_end;
  assign bad_word = (in_data[3:0] == 4'd0) | (in_data[15:4] != 12'd0);

  // operand j lands at row j%ROWS, column j/ROWS
  assign op_row  = 32'(idx_q) % 32'(ROWS);
  assign op_col  = 32'(idx_q) / 32'(ROWS);
  assign op_addr = 10'(op_row * 32'(COL_DEPTH) + op_col);

  assign busy     = run & (state_q != S_IDLE);
  assign err      = run & err_q;
  assign sa_rst   = run & (state_q == S_SRST);
  assign enI      = run & (((state_q == S_LDI) & in_valid) |
                           (state_q == S_TERM));
  assign addrI    = !enI ? 3'd0 :
                    (state_q == S_TERM) ? ninstr_q : idx_q[2:0];
  assign dataI    = (enI & (state_q == S_LDI)) ? in_data[3:0] : 4'd0;
  assign enA      = run & (state_q == S_LDA) & in_valid;
  assign addrA    = enA ? op_addr : 10'd0;
  assign dataA    = enA ? in_data : 16'd0;
  assign enB      = run & (state_q == S_LDB) & in_valid;
  assign addrB    = enB ? op_addr : 10'd0;
  assign dataB    = enB ? in_data : 16'd0;
  assign ap_start = run & (state_q == S_START);
  assign addrO    = run ? raddr_q : 7'd0;
  assign out_valid = run & (state_q == S_RDO);
  assign out_data = out_valid ? odata_q : 32'd0;
  assign out_last = out_valid & res_last;

  // job sequencing: load, terminate, start, wait, drain
  always_comb begin
    state_d  = state_q;
    ninstr_d = ninstr_q;
    ncols_d  = ncols_q;
    idx_d    = idx_q;
    raddr_d  = raddr_q;
    odata_d  = odata_q;
    err_d    = err_q;
`ifdef SA_DRV_TIMEOUT_EN
    wcnt_d   = wcnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (job_start) begin
          ninstr_d = (job_ninstr == 3'd0) ? 3'd1 : job_ninstr;
          ncols_d  = (job_ncols == 9'd0) ? 9'd1 : job_ncols;
          err_d    = 1'b0;
          idx_d    = '0;
          raddr_d  = '0;
          state_d  = S_SRST;
        end
      end
      S_SRST: begin
        if (idx_q[0]) begin
          idx_d   = '0;
          state_d = S_LDI;
        end else begin
          idx_d = 10'd1;
        end
      end
      S_LDI: begin
        if (xfer) begin
          if (bad_word) err_d = 1'b1;
          if (in_end) begin
            idx_d   = '0;
            state_d = S_LDA;
          end else begin
            idx_d = idx_q + 10'd1;
          end
        end
      end
      S_LDA: begin
        if (xfer) begin
          if (op_end) begin
            idx_d   = '0;
            state_d = S_LDB;
          end else begin
            idx_d = idx_q + 10'd1;
          end
        end
      end
      S_LDB: begin
        if (xfer) begin
          if (op_end) begin
            idx_d   = '0;
            state_d = S_TERM;
          end else begin
            idx_d = idx_q + 10'd1;
          end
        end
      end
      S_TERM: state_d = S_START;
      S_START: begin
        state_d = S_WAIT;
`ifdef SA_DRV_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      S_WAIT: begin
        if (ap_done == 1'b1) state_d = S_RDA;
`ifdef SA_DRV_TIMEOUT_EN
        else if (wcnt_q == 32'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 32'd1;
        end
`endif
      end
      S_RDA: state_d = S_RDD;
      S_RDD: begin
        odata_d = dataO;
        state_d = S_RDO;
      end
      S_RDO: begin
        if (out_ready) begin
          if (res_last) begin
            state_d = S_IDLE;
          end else begin
            raddr_d = raddr_q + 7'd1;
            state_d = S_RDA;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ninstr_q <= '0;
      ncols_q  <= '0;
      idx_q    <= '0;
      raddr_q  <= '0;
      odata_q  <= '0;
      err_q    <= 1'b0;
`ifdef SA_DRV_TIMEOUT_EN
      wcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ninstr_q <= ninstr_d;
      ncols_q  <= ncols_d;
      idx_q    <= idx_d;
      raddr_q  <= raddr_d;
      odata_q  <= odata_d;
      err_q    <= err_d;
`ifdef SA_DRV_TIMEOUT_EN
      wcnt_q   <= wcnt_d;
`endif
    end
  end

endmodule
